// File: rtl/fifo_ctrl.sv
// fifo_ctrl: eight-entry, 32-bit FIFO controller driving an external 8x32
// register file. It owns head/tail pointers, occupancy and handshake status.
// Read data is captured from the register file into a registered dout.
module fifo_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        full,
  output logic        empty,
  output logic [3:0]  data_count,
  output logic        wr_ack,
  output logic        wr_err,
  output logic        rd_ack,
  output logic        rd_err,
  output logic        rf_we,
  output logic [2:0]  rf_wAddr,
  output logic [31:0] rf_wData,
  output logic [2:0]  rf_rAddr,
  input  logic [31:0] rf_rData
);

  logic [2:0]  head_r;
  logic [2:0]  tail_r;
  logic [3:0]  count_r;
  logic [31:0] dout_r;
  logic        wr_ack_r;
  logic        wr_err_r;
  logic        rd_ack_r;
  logic        rd_err_r;

  logic        full_s;
  logic        empty_s;
  logic        do_wr_s;
  logic        do_rd_s;
  logic [3:0]  count_nxt_s;

  // Occupancy flags follow the count committed at the last edge
  always_comb begin
    full_s  = (count_r == 4'd8);
    empty_s = (count_r == 4'd0);
  end

  // Request decode: a read on a full FIFO frees the slot a same-cycle write reuses
  always_comb begin
    do_rd_s = rd_en & ~empty_s;
    do_wr_s = wr_en & (~full_s | do_rd_s);
  end

  // Next occupancy: simultaneous read and write leave the count unchanged
  always_comb begin
    count_nxt_s = count_r;
    case ({do_wr_s, do_rd_s})
      2'b10:   count_nxt_s = count_r + 4'd1;
      2'b01:   count_nxt_s = count_r - 4'd1;
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointer, count and read-data state; dout takes the pre-write slot contents
  always_ff @(posedge clk) begin
    if (reset) begin
      head_r  <= 3'd0;
      tail_r  <= 3'd0;
      count_r <= 4'd0;
      dout_r  <= 32'd0;
    end else begin
      if (do_wr_s) begin
        tail_r <= tail_r + 3'd1;
      end
      if (do_rd_s) begin
        head_r <= head_r + 3'd1;
        dout_r <= rf_rData;
      end
      count_r <= count_nxt_s;
    end
  end

  // Handshake status reports the outcome of the previous cycle's requests
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ack_r <= 1'b0;
      wr_err_r <= 1'b0;
      rd_ack_r <= 1'b0;
      rd_err_r <= 1'b0;
    end else begin
      wr_ack_r <= do_wr_s;
      wr_err_r <= wr_en & ~do_wr_s;
      rd_ack_r <= do_rd_s;
      rd_err_r <= rd_en & ~do_rd_s;
    end
  end

  // Register-file port drive; the write enable is blocked while reset is high
  always_comb begin
    rf_we    = do_wr_s & ~reset;
    rf_wAddr = tail_r;
    rf_wData = din;
    rf_rAddr = head_r;
  end

  // Output mapping
  always_comb begin
    dout       = dout_r;
    full       = full_s;
    empty      = empty_s;
    data_count = count_r;
    wr_ack     = wr_ack_r;
    wr_err     = wr_err_r;
    rd_ack     = rd_ack_r;
    rd_err     = rd_err_r;
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Testbench for fifo_ctrl: register-file model plus a queue-based FIFO
// reference. Registered outputs and the write strobe are compared against
// the reference on every falling edge; directed literals pin the reference.
module tb_fifo_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] din = 32'd0;
  logic [31:0] dout;
  logic        full, empty;
  logic [3:0]  data_count;
  logic        wr_ack, wr_err, rd_ack, rd_err;
  logic        rf_we;
  logic [2:0]  rf_wAddr, rf_rAddr;
  logic [31:0] rf_wData, rf_rData;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  fifo_ctrl dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .rd_en(rd_en), .din(din),
    .dout(dout), .full(full), .empty(empty), .data_count(data_count),
    .wr_ack(wr_ack), .wr_err(wr_err), .rd_ack(rd_ack), .rd_err(rd_err),
    .rf_we(rf_we), .rf_wAddr(rf_wAddr), .rf_wData(rf_wData),
    .rf_rAddr(rf_rAddr), .rf_rData(rf_rData)
  );

  // 8x32 register file: synchronous write, asynchronous read
  logic [31:0] mem [8];
  initial for (int i = 0; i < 8; i++) mem[i] = 32'd0;
  always_ff @(posedge clk) if (rf_we) mem[rf_wAddr] <= rf_wData;
  assign rf_rData = mem[rf_rAddr];

  // Reference model: m_* is the state after the last edge, n_* after the next
  logic [31:0] mq[$], nq[$];
  logic [31:0] m_dout = 32'd0, n_dout = 32'd0;
  logic m_wack = 1'b0, m_werr = 1'b0, m_rack = 1'b0, m_rerr = 1'b0;
  logic n_wack = 1'b0, n_werr = 1'b0, n_rack = 1'b0, n_rerr = 1'b0;
  logic e_we = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: commit the prediction, apply inputs, predict the next edge
  task automatic step(input logic rst, input logic w, input logic r, input logic [31:0] d);
    logic dw, dr;
    @(posedge clk);
    #2;
    mq = nq;
    m_dout = n_dout;
    m_wack = n_wack; m_werr = n_werr; m_rack = n_rack; m_rerr = n_rerr;
    reset = rst; wr_en = w; rd_en = r; din = d;
    nq = mq;
    if (rst) begin
      nq.delete();
      n_dout = 32'd0;
      n_wack = 1'b0; n_werr = 1'b0; n_rack = 1'b0; n_rerr = 1'b0;
      e_we = 1'b0;
    end else begin
      dr = r && (mq.size() > 0);
      dw = w && ((mq.size() < 8) || dr);
      if (dr) n_dout = nq.pop_front();
      if (dw) nq.push_back(d);
      n_wack = dw; n_werr = w && !dw; n_rack = dr; n_rerr = r && !dr;
      e_we = dw;
    end
    #1;
  endtask

  // Per-cycle comparison against the reference, away from the rising edge
  always @(negedge clk) begin
    if (check_en) begin
      chk("dout", dout, m_dout);
      chk("data_count", {28'd0, data_count}, mq.size());
      chk("full", {31'd0, full}, {31'd0, mq.size() == 8});
      chk("empty", {31'd0, empty}, {31'd0, mq.size() == 0});
      chk("wr_ack", {31'd0, wr_ack}, {31'd0, m_wack});
      chk("wr_err", {31'd0, wr_err}, {31'd0, m_werr});
      chk("rd_ack", {31'd0, rd_ack}, {31'd0, m_rack});
      chk("rd_err", {31'd0, rd_err}, {31'd0, m_rerr});
      chk("rf_we", {31'd0, rf_we}, {31'd0, e_we});
      chk("rf_wData", rf_wData, din);
    end
  end

  logic [31:0] pat;

  initial begin
    // Reset, then idle
    step(1'b1, 1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b1, 1'b0, 32'h12345678);
    chk("rf_we_in_reset", {31'd0, rf_we}, 32'd0);
    check_en = 1'b1;
    step(1'b0, 1'b0, 1'b0, 32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_count", {28'd0, data_count}, 32'd0);
    chk("rst_dout", dout, 32'd0);
    chk("rst_flags", {28'd0, wr_ack, wr_err, rd_ack, rd_err}, 32'd0);

    // Fill with 0x11111111..0x88888888
    for (int k = 1; k <= 8; k++) begin
      pat = 32'h11111111 * k;
      step(1'b0, 1'b1, 1'b0, pat);
    end
    step(1'b0, 1'b1, 1'b0, 32'hDEADBEEF);
    chk("wr_full_rf_we", {31'd0, rf_we}, 32'd0);
    chk("last_wr_ack", {31'd0, wr_ack}, 32'd1);
    chk("full_count", {28'd0, data_count}, 32'd8);
    chk("full_flag", {31'd0, full}, 32'd1);
    step(1'b0, 1'b0, 1'b0, 32'd0);
    chk("wr_err_full", {31'd0, wr_err}, 32'd1);
    chk("count_after_rej", {28'd0, data_count}, 32'd8);

    // Drain in order, then one read too many
    for (int k = 0; k <= 8; k++) begin
      step(1'b0, 1'b0, k < 8, 32'd0);
      if (k > 0) begin
        pat = 32'h11111111 * k;
        chk("drain_dout", dout, pat);
        chk("drain_rd_ack", {31'd0, rd_ack}, 32'd1);
      end
    end
    chk("drained_empty", {31'd0, empty}, 32'd1);
    step(1'b0, 1'b0, 1'b1, 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'd0);
    chk("rd_err_empty", {31'd0, rd_err}, 32'd1);
    chk("dout_hold", dout, 32'h88888888);

    // Pointer wrap: write 5, read 5, then write 6 and read 6
    for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 1'b0, 32'hA000_0000 + k);
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b1, 32'd0);
    for (int k = 0; k < 6; k++) step(1'b0, 1'b1, 1'b0, 32'hB000_0000 + k);
    chk("wrap_count", {28'd0, data_count}, 32'd5);
    for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 1'b1, 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'd0);
    chk("wrap_last", dout, 32'hB000_0005);
    chk("wrap_empty", {31'd0, empty}, 32'd1);

    // Simultaneous at count 3
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0, 32'h30 + k);
    step(1'b0, 1'b1, 1'b1, 32'h33);
    step(1'b0, 1'b0, 1'b0, 32'd0);
    chk("both_mid_count", {28'd0, data_count}, 32'd3);
    chk("both_mid_dout", dout, 32'h30);

    // Simultaneous at full: write lands on the slot being read
    for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 1'b0, 32'h40 + k);
    step(1'b0, 1'b1, 1'b1, 32'h99);
    step(1'b0, 1'b0, 1'b0, 32'd0);
    chk("both_full_count", {28'd0, data_count}, 32'd8);
    chk("both_full_dout", dout, 32'h31);
    for (int k = 0; k < 8; k++) step(1'b0, 1'b0, 1'b1, 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'd0);
    chk("both_full_tail", dout, 32'h99);

    // Simultaneous at empty: no fall-through
    step(1'b0, 1'b1, 1'b1, 32'h77);
    step(1'b0, 1'b0, 1'b0, 32'd0);
    chk("both_empty_wack", {31'd0, wr_ack}, 32'd1);
    chk("both_empty_rerr", {31'd0, rd_err}, 32'd1);
    chk("both_empty_count", {28'd0, data_count}, 32'd1);

    // Reset mid-operation discards contents
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b0, 32'hC0 + k);
    step(1'b1, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b1, 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'd0);
    chk("post_rst_rerr", {31'd0, rd_err}, 32'd1);
    chk("post_rst_empty", {31'd0, empty}, 32'd1);
    step(1'b0, 1'b1, 1'b0, 32'hA5A5A5A5);
    step(1'b0, 1'b0, 1'b1, 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'd0);
    chk("post_rst_data", dout, 32'hA5A5A5A5);
    step(1'b0, 1'b0, 1'b0, 32'd0);

    @(posedge clk);
    #2;
    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
